clk_div_bank: RTL and testbench
===============================

# clk_div_bank

Lock-qualified, multi-channel programmable clock divider in the PLL output domain. Takes the rPLL output clock and its raw `lock`, qualifies lock for a programmable settling time, and produces NCH independent registered 50%-duty divided clocks with matching one-cycle enable strobes. Divide ratios are runtime-writable and update glitch-free at period boundaries; all channels start phase-aligned when lock qualifies.

## Interface
- NCH, 4, number of divider channels (1..16)
- DIV_W, 16, width of divide value
- LOCK_STABLE, 1024, cycles `pll_lock` must stay synced-high before `ready` (≥1)
- DIV_RST, 49, reset value of every channel's divide register
- CH_W (localparam), max(1, clog2(NCH)), channel-select width

- clkin  in  1  clock: PLL output; all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- pll_lock  in  1  raw PLL lock, asynchronous to clkin
- div_wr  in  1  write strobe, one cycle
- div_ch  in  CH_W  target channel for write
- div_val  in  DIV_W  half-period minus one
- ch_en  in  NCH  per-channel run enable
- clkout  out  NCH  divided clocks (registered)
- ce  out  NCH  one-cycle strobe coincident with each `clkout` rising
- ready  out  1  lock qualified, channels may run

## Operation
- Reset: `clkout`=0, `ce`=0, `ready`=0, lock counter=0, all active and shadow divide registers=DIV_RST, all channels STOPPED.
- Lock qualify: `pll_lock` → 2-flop synchroniser → `lock_s`. While `lock_s`=1, counter increments, saturating at LOCK_STABLE; `ready`=1 when saturated. `lock_s`=0 clears counter and `ready` the same edge.
- Channel states: STOPPED, HIGH, LOW.
  - STOPPED: `clkout`=0, count=0. If `ready` & `ch_en[i]`: load active←shadow, → HIGH, `clkout`=1, `ce`=1.
  - HIGH: count to active value (active+1 cycles high), then → LOW, `clkout`=0.
  - LOW: count active+1 cycles; at terminal: if `ready` & `ch_en[i]` → HIGH with active←shadow, `clkout`=1, `ce`=1; else → STOPPED.
- Period = 2·(div+1) cycles; div=0 gives clkin/2.
- `ch_en[i]` falling mid-period: current period completes (no runt high phase).
- `ready` falling: every channel → STOPPED next edge, `clkout`=0 immediately (runt allowed; clock is invalid).
- Writes: `div_wr` writes `div_val` into shadow[`div_ch`]; no backpressure, every cycle accepted; later write before boundary overwrites. `div_ch` ≥ NCH ignored. Write to a STOPPED channel also loads active.
- Enabled channels leaving STOPPED on the same cycle rise on the same edge (phase-aligned).

## Timing
- `ready` rises LOCK_STABLE+2 to LOCK_STABLE+3 edges after `pll_lock` rises; falls 2–3 edges after `pll_lock` falls.
- Channel start: `clkout`/`ce` high on the edge after `ready`&`ch_en` first sampled high.
- Divide update latency: takes effect at next HIGH entry; never alters a period in progress.
- All outputs registered; no combinational input→output path.
- Counters DIV_W bits, compare equal to active value; no wrap possible.

## Structure
- Package `clk_div_pkg`: DIV_W default, channel state enum (STOPPED/HIGH/LOW), clog2 helper.
- Sub-module `clk_div_chan`: one channel (state, counter, shadow/active registers, `clkout`/`ce` flops), generate-instantiated NCH times. Top holds synchroniser, lock counter, write decode.

## Test plan
- Reset, LOCK_STABLE=8, `pll_lock` high at t0 → `ready` rises at edge 10 or 11; `clkout`=0 throughout before.
- `ch_en`=4'b1111, divs 0,1,2,49 → periods 2,4,6,100 cycles, 50% duty, all rising on same edge; `ce` high exactly on rising edges.
- Channel 1 div=3 running, write div=0 mid-HIGH → current period 8 cycles, next period 2.
- Two writes (5 then 7) to ch2 within one period → next period 16; write with `div_ch`=5 (NCH=4) → no change anywhere.
- `ch_en[0]` low in HIGH phase of div=4 → full 10-cycle period completes, then `clkout[0]`=0 held.
- `pll_lock` drops while running → within 3 edges `ready`=0, all `clkout`=0, `ce`=0; re-lock → aligned restart after LOCK_STABLE; async `rst_n` mid-period → outputs 0 immediately.

Source files
------------

// File: rtl/clk_div_pkg.sv
// clk_div_pkg: shared types and helpers for the clk_div_bank divider slice.
//   DIV_W_DEF   : default divide-value width
//   ch_state_e  : per-channel divider state (STOPPED / HIGH / LOW)
//   clog2()     : ceil(log2(n)), never less than 1 (usable as a field width)
package clk_div_pkg;

  localparam int DIV_W_DEF = 16;

  typedef enum logic [1:0] {
    ST_STOP = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } ch_state_e;

  function automatic int clog2(input int n);
    int r;
    r = 1;
    while ((1 << r) < n) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/clk_div_bank_if.sv
// clk_div_bank_if: control/status bundle of the divider bank.
//   div_wr/div_ch/div_val : one-cycle divide-register write (half-period minus one)
//   ch_en                 : per-channel run enable
//   clkout/ce/ready       : divided clocks, rising-edge strobes, lock-qualified flag
// master = controller side, slave = clk_div_bank.
interface clk_div_bank_if #(
  parameter int NCH   = 4,
  parameter int DIV_W = clk_div_pkg::DIV_W_DEF
);
  localparam int CH_W = clk_div_pkg::clog2(NCH);

  logic              div_wr;
  logic [CH_W-1:0]   div_ch;
  logic [DIV_W-1:0]  div_val;
  logic [NCH-1:0]    ch_en;
  logic [NCH-1:0]    clkout;
  logic [NCH-1:0]    ce;
  logic              ready;

  modport master (output div_wr, div_ch, div_val, ch_en, input clkout, ce, ready);
  modport slave  (input div_wr, div_ch, div_val, ch_en, output clkout, ce, ready);
endinterface

// File: rtl/clk_div_chan.sv
// clk_div_chan: one 50%-duty divider channel.
//   clkin/rst_n : PLL-domain clock, async active-low reset
//   run         : lock qualified; dropping it stops the channel at once
//   en          : channel enable, sampled only at period boundaries
//   wr/wval     : shadow divide write (also loads active while stopped)
//   clkout/ce   : registered divided clock and its rising-edge strobe
// High and low phases each last active+1 cycles; the active value is only
// reloaded from the shadow on entry to HIGH, so a period never changes mid-way.
module clk_div_chan import clk_div_pkg::*; #(
  parameter int DIV_W   = DIV_W_DEF,
  parameter int DIV_RST = 49
) (
  input  logic             clkin,
  input  logic             rst_n,
  input  logic             run,
  input  logic             en,
  input  logic             wr,
  input  logic [DIV_W-1:0] wval,
  output logic             clkout,
  output logic             ce
);

  localparam logic [DIV_W-1:0] RST_VAL = DIV_W'(DIV_RST);

  ch_state_e        state, state_nxt;
  logic [DIV_W-1:0] cnt, cnt_nxt;
  logic [DIV_W-1:0] act, act_nxt;
  logic [DIV_W-1:0] shd, shd_nxt;
  logic             clk_nxt, ce_nxt;

  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_STOP;
      cnt    <= '0;
      act    <= RST_VAL;
      shd    <= RST_VAL;
      clkout <= 1'b0;
      ce     <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      act    <= act_nxt;
      shd    <= shd_nxt;
      clkout <= clk_nxt;
      ce     <= ce_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    act_nxt   = act;
    clk_nxt   = clkout;
    ce_nxt    = 1'b0;
    // a write landing on the reload edge is the value that gets loaded
    shd_nxt   = wr ? wval : shd;

    case (state)
      ST_STOP: begin
        cnt_nxt = '0;
        clk_nxt = 1'b0;
        if (wr) act_nxt = wval;
        if (run && en) begin
          state_nxt = ST_HIGH;
          act_nxt   = shd_nxt;
          clk_nxt   = 1'b1;
          ce_nxt    = 1'b1;
        end
      end
      ST_HIGH: begin
        if (cnt == act) begin
          state_nxt = ST_LOW;
          cnt_nxt   = '0;
          clk_nxt   = 1'b0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      ST_LOW: begin
        if (cnt == act) begin
          cnt_nxt = '0;
          if (run && en) begin
            state_nxt = ST_HIGH;
            act_nxt   = shd_nxt;
            clk_nxt   = 1'b1;
            ce_nxt    = 1'b1;
          end else begin
            state_nxt = ST_STOP;
          end
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: begin
        state_nxt = ST_STOP;
        cnt_nxt   = '0;
        clk_nxt   = 1'b0;
      end
    endcase

    // lost lock: output is meaningless, kill it immediately (runt allowed)
    if (!run && state != ST_STOP) begin
      state_nxt = ST_STOP;
      cnt_nxt   = '0;
      clk_nxt   = 1'b0;
      ce_nxt    = 1'b0;
    end
  end

endmodule

// File: rtl/clk_div_bank.sv
// clk_div_bank: lock-qualified bank of NCH programmable clock dividers.
//   clkin    : PLL output clock, all logic on its rising edge
//   rst_n    : async active-low reset
//   pll_lock : raw PLL lock (asynchronous, synchronised here)
//   bus      : clk_div_bank_if.slave -- divide writes, enables, clkout/ce/ready
// Lock must stay synced-high LOCK_STABLE cycles before ready; channels
// released on the same edge start phase-aligned.
module clk_div_bank import clk_div_pkg::*; #(
  parameter int NCH         = 4,
  parameter int DIV_W       = DIV_W_DEF,
  parameter int LOCK_STABLE = 1024,
  parameter int DIV_RST     = 49
) (
  input  logic           clkin,
  input  logic           rst_n,
  input  logic           pll_lock,
  clk_div_bank_if.slave  bus
);

  localparam int CH_W = clog2(NCH);
  localparam int LCW  = clog2(LOCK_STABLE + 1);
  localparam logic [LCW-1:0] LOCK_MAX = LCW'(LOCK_STABLE);

  logic           lock_m, lock_s;
  logic [LCW-1:0] lock_cnt;
  logic           ready_q;
  logic           run;
  logic [NCH-1:0] clk_o, ce_o;

  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      lock_m <= 1'b0;
      lock_s <= 1'b0;
    end else begin
      lock_m <= pll_lock;
      lock_s <= lock_m;
    end
  end

  // ready registers on the same edge the counter saturates
  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      lock_cnt <= '0;
      ready_q  <= 1'b0;
    end else if (!lock_s) begin
      lock_cnt <= '0;
      ready_q  <= 1'b0;
    end else if (lock_cnt != LOCK_MAX) begin
      lock_cnt <= lock_cnt + 1'b1;
      ready_q  <= (lock_cnt + 1'b1) == LOCK_MAX;
    end
  end

  // Gating with lock_s lets channels stop on the same edge ready falls,
  // while a start still needs ready to have been registered high first.
  assign run = ready_q & lock_s;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    clk_div_chan #(.DIV_W(DIV_W), .DIV_RST(DIV_RST)) u_chan (
      .clkin  (clkin),
      .rst_n  (rst_n),
      .run    (run),
      .en     (bus.ch_en[i]),
      .wr     (bus.div_wr && (bus.div_ch == CH_W'(i))),
      .wval   (bus.div_val),
      .clkout (clk_o[i]),
      .ce     (ce_o[i])
    );
  end

  assign bus.clkout = clk_o;
  assign bus.ce     = ce_o;
  assign bus.ready  = ready_q;

endmodule

// File: tb/tb_clk_div_bank.sv
// tb_clk_div_bank: directed bench for clk_div_bank.
// u_dut  : NCH=4, LOCK_STABLE=8, DIV_RST=49 -- main scenarios.
// u_dut3 : NCH=3, LOCK_STABLE=2, DIV_RST=1  -- out-of-range div_ch is representable.
module tb_clk_div_bank;

  logic clkin = 1'b0;
  logic rst_n = 1'b0;
  logic pll_lock = 1'b0;

  always #5 clkin = ~clkin;

  clk_div_bank_if #(.NCH(4), .DIV_W(16)) b4 ();
  clk_div_bank_if #(.NCH(3), .DIV_W(16)) b3 ();

  clk_div_bank #(.NCH(4), .DIV_W(16), .LOCK_STABLE(8), .DIV_RST(49)) u_dut (
    .clkin(clkin), .rst_n(rst_n), .pll_lock(pll_lock), .bus(b4.slave));

  clk_div_bank #(.NCH(3), .DIV_W(16), .LOCK_STABLE(2), .DIV_RST(1)) u_dut3 (
    .clkin(clkin), .rst_n(rst_n), .pll_lock(pll_lock), .bus(b3.slave));

  logic [6:0] clk_all;
  assign clk_all = {b3.clkout, b4.clkout};

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ce must be high exactly on the cycle clkout goes 0->1
  logic [3:0] clk_prev = '0;
  always @(negedge clkin) begin
    chk("ce_edge", 32'(b4.ce), 32'(b4.clkout & ~clk_prev));
    clk_prev <= b4.clkout;
  end

  // one-cycle write, called at a negedge, returns at the next negedge
  task automatic wr(input bit on3, input int ch, input int val);
    if (on3) begin
      b3.div_wr = 1'b1; b3.div_ch = 2'(ch); b3.div_val = 16'(val);
    end else begin
      b4.div_wr = 1'b1; b4.div_ch = 2'(ch); b4.div_val = 16'(val);
    end
    @(negedge clkin);
    b3.div_wr = 1'b0;
    b4.div_wr = 1'b0;
  endtask

  // measure one period (rise to rise) of clk_all[idx]; -1 on timeout.
  // at_rise: caller is at the negedge on which the rise was just seen.
  task automatic meas(input int idx, input bit at_rise, output int hi, output int per);
    logic prev;
    bit   got, done;
    int   h, p;
    hi = -1; per = -1;
    got = at_rise;
    prev = clk_all[idx];
    for (int n = 0; n < 400 && !got; n++) begin
      @(negedge clkin);
      if (!prev && clk_all[idx]) got = 1'b1;
      prev = clk_all[idx];
    end
    if (!got) return;
    h = 1; p = 1; prev = 1'b1; done = 1'b0;
    for (int n = 0; n < 400 && !done; n++) begin
      @(negedge clkin);
      if (!prev && clk_all[idx]) done = 1'b1;
      else begin
        p++;
        if (clk_all[idx]) h++;
      end
      prev = clk_all[idx];
    end
    if (done) begin hi = h; per = p; end
  endtask

  initial begin
    int h, p, e, rises;
    bit seen;
    int exp_hi [4] = '{1, 2, 3, 50};
    int exp_per[4] = '{2, 4, 6, 100};

    b4.div_wr = 1'b0; b4.div_ch = '0; b4.div_val = '0; b4.ch_en = '0;
    b3.div_wr = 1'b0; b3.div_ch = '0; b3.div_val = '0; b3.ch_en = 3'b111;

    // reset state
    repeat (2) @(posedge clkin);
    #1;
    chk("rst_ready", 32'(b4.ready), 0);
    chk("rst_clk",   32'(b4.clkout), 0);
    chk("rst_ce",    32'(b4.ce), 0);

    // lock qualification: ready on edge 10 or 11, clkout quiet before
    @(negedge clkin) rst_n = 1'b1;
    @(posedge clkin); #1 pll_lock = 1'b1;
    seen = 1'b0; e = 0;
    for (int i = 1; i <= 40 && !seen; i++) begin
      @(posedge clkin); #1;
      e = i;
      if (b4.ready) seen = 1'b1;
      else chk("pre_clk", 32'(b4.clkout), 0);
    end
    chk("rdy_edge", 32'(seen && e >= 10 && e <= 11), 1);

    // program divs while stopped, then release all four together
    @(negedge clkin);
    wr(0, 0, 0); wr(0, 1, 1); wr(0, 2, 2); wr(0, 3, 49);
    b4.ch_en = 4'hF;
    @(posedge clkin); #1;
    chk("start_clk", 32'(b4.clkout), 32'hF);
    chk("start_ce",  32'(b4.ce), 32'hF);
    for (int c = 0; c < 4; c++) begin
      meas(c, 0, h, p);
      chk($sformatf("hi_ch%0d", c), 32'(h), 32'(exp_hi[c]));
      chk($sformatf("per_ch%0d", c), 32'(p), 32'(exp_per[c]));
    end

    // ch1: div=3, then rewrite to 0 mid-HIGH
    wr(0, 1, 3);
    meas(1, 0, h, p);
    chk("d3_per", 32'(p), 8);
    fork
      meas(1, 1, h, p);
      wr(0, 1, 0);
    join
    chk("d3_cur_hi",  32'(h), 4);
    chk("d3_cur_per", 32'(p), 8);
    meas(1, 1, h, p);
    chk("d0_per", 32'(p), 2);
    chk("d0_hi",  32'(h), 1);

    // ch2: two writes within one period, last one wins
    wr(0, 2, 5); wr(0, 2, 7);
    meas(2, 0, h, p);
    chk("ow_per", 32'(p), 16);
    chk("ow_hi",  32'(h), 8);
    meas(0, 0, h, p);
    chk("ch0_keep", 32'(p), 2);

    // out-of-range channel on the 3-channel bank: no channel changes
    wr(1, 3, 0);
    for (int c = 0; c < 3; c++) begin
      meas(4 + c, 0, h, p);
      chk($sformatf("oor_per%0d", c), 32'(p), 4);
    end

    // ch0 div=4, enable dropped in HIGH: full 5-cycle high, then held low
    wr(0, 0, 4);
    meas(0, 0, h, p);
    chk("d4_per", 32'(p), 10);
    b4.ch_en[0] = 1'b0;
    h = 1; rises = 0; seen = 1'b1;
    for (int n = 0; n < 40; n++) begin
      @(negedge clkin);
      if (clk_all[0]) h++;
      if (!seen && clk_all[0]) rises++;
      seen = clk_all[0];
    end
    chk("en_hi",   32'(h), 5);
    chk("en_rise", 32'(rises), 0);
    chk("en_low",  32'(b4.clkout[0]), 0);

    // lock loss while running
    b4.ch_en = 4'hF;
    @(posedge clkin); #1 pll_lock = 1'b0;
    repeat (3) @(posedge clkin);
    #1;
    chk("ll_ready", 32'(b4.ready), 0);
    chk("ll_clk",   32'(b4.clkout), 0);
    chk("ll_ce",    32'(b4.ce), 0);

    // re-lock: aligned restart one edge after ready
    pll_lock = 1'b1;
    seen = 1'b0; e = 0;
    for (int i = 1; i <= 40 && !seen; i++) begin
      @(posedge clkin); #1;
      e = i;
      if (b4.clkout != 0) seen = 1'b1;
    end
    chk("rl_edge", 32'(seen && e >= 11 && e <= 12), 1);
    chk("rl_clk",  32'(b4.clkout), 32'hF);
    chk("rl_ce",   32'(b4.ce), 32'hF);
    @(negedge clkin);
    meas(1, 1, h, p);
    chk("rl_per1", 32'(p), 2);

    // async reset mid-period
    chk("pre_rst", 32'(b4.clkout[3]), 1);
    @(posedge clkin); #3 rst_n = 1'b0;
    #1;
    chk("ar_clk",   32'(b4.clkout), 0);
    chk("ar_ce",    32'(b4.ce), 0);
    chk("ar_ready", 32'(b4.ready), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
